// File: rtl/mcu51_timing_pkg.sv
// Shared slot constants, instruction-latch type and MOVX decode for the
// MCU51 machine-cycle timing generator.
package mcu51_timing_pkg;

  localparam logic [3:0] T_ALE0       = 4'd1;
  localparam logic [3:0] T_PSEN0      = 4'd3;
  localparam logic [3:0] T_STROBE_END = 4'd5;
  localparam logic [3:0] T_ALE1       = 4'd7;
  localparam logic [3:0] T_PSEN1      = 4'd9;
  localparam logic [3:0] T_LAST       = 4'd11;

  typedef struct packed {
    logic       movx;
    logic       wr;
    logic [1:0] len;
    logic       ea_l;
  } instr_t;

  // MOVX A,@Ri / MOVX A,@DPTR / MOVX @Ri,A / MOVX @DPTR,A
  function automatic logic is_movx(input logic [7:0] ir);
    return (ir[7:5] == 3'b111) && (ir[3:2] == 2'b00) && (ir[1] || !ir[0]);
  endfunction

  function automatic instr_t decode_instr(input logic [7:0] ir,
                                          input logic [1:0] mc_len,
                                          input logic       ea);
    instr_t d;
    d.movx = is_movx(ir);
    d.wr   = d.movx && ir[4];
    // A MOVX needs its second machine cycle for the data strobe.
    d.len  = (d.movx && (mc_len == 2'd0)) ? 2'd1 : mc_len;
    d.ea_l = ea;
    return d;
  endfunction

endpackage

// File: rtl/mc_timing_gen_if.sv
// Decoder-side inputs and bus-pin outputs of the timing generator.
interface mc_timing_gen_if;
  logic       EA;
  logic [7:0] IR;
  logic [1:0] mc_len;
  logic       ready;
  logic       Phase;
  logic [2:0] state;
  logic [1:0] cycles;
  logic       ALE;
  logic       PSEN_n;
  logic       RD_n;
  logic       WR_n;
  logic       instr_start;
  logic       instr_done;
  logic       wait_timeout;

  modport master (
    input  EA, IR, mc_len, ready,
    output Phase, state, cycles, ALE, PSEN_n, RD_n, WR_n,
           instr_start, instr_done, wait_timeout
  );

  modport slave (
    output EA, IR, mc_len, ready,
    input  Phase, state, cycles, ALE, PSEN_n, RD_n, WR_n,
           instr_start, instr_done, wait_timeout
  );
endinterface

// File: rtl/mc_slot_counter.sv
// Clock divider, slot index (0..11) and machine-cycle counter with a freeze
// input that holds divider and slot during external wait states.
module mc_slot_counter
  import mcu51_timing_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic [1:0] len,
  output logic [3:0] slot,
  output logic [1:0] cycles,
  output logic       div_zero,
  output logic       slot_end,
  output logic       instr_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [3:0]       slot_reg, slot_next;
  logic [1:0]       cyc_reg, cyc_next;

  assign slot      = slot_reg;
  assign cycles    = cyc_reg;
  assign div_zero  = (div_reg == '0);
  assign slot_end  = (div_reg == DIV_LAST);
  assign instr_end = slot_end && (slot_reg == T_LAST) && (cyc_reg == len) && !freeze;

  always_comb begin
    div_next  = div_reg;
    slot_next = slot_reg;
    cyc_next  = cyc_reg;
    if (!freeze) begin
      if (slot_end) begin
        div_next = '0;
        if (slot_reg == T_LAST) begin
          slot_next = 4'd0;
          cyc_next  = (cyc_reg == len) ? 2'd0 : cyc_reg + 2'd1;
        end else begin
          slot_next = slot_reg + 4'd1;
        end
      end else begin
        div_next = div_reg + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg  <= '0;
      slot_reg <= 4'd0;
      cyc_reg  <= 2'd0;
    end else begin
      div_reg  <= div_next;
      slot_reg <= slot_next;
      cyc_reg  <= cyc_next;
    end
  end

endmodule

// File: rtl/mc_timing_gen.sv
// MCU51 machine-cycle sequencer: S-state/phase, ALE, PSEN_n and MOVX
// RD_n/WR_n strobes with ready-driven wait states and a wait timeout.
module mc_timing_gen
  import mcu51_timing_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter bit WAIT_EN  = 1'b1,
  parameter int WAIT_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  mc_timing_gen_if.master   bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

  instr_t     instr_reg;
  logic [3:0] wait_cnt_reg, wait_cnt_next;

  logic [3:0] slot;
  logic [1:0] cycles;
  logic       div_zero;
  logic       slot_end;
  logic       instr_end;
  logic       at_strobe_end;
  logic       wait_hold;
  logic       freeze;
  logic       timeout_hit;

  mc_slot_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_slot_counter (
    .clk       (clk),
    .reset     (reset),
    .freeze    (freeze),
    .len       (instr_reg.len),
    .slot      (slot),
    .cycles    (cycles),
    .div_zero  (div_zero),
    .slot_end  (slot_end),
    .instr_end (instr_end)
  );

  // Ready only matters on the last clock of the MOVX strobe window.
  assign at_strobe_end = instr_reg.movx && (cycles == 2'd1) &&
                         (slot == T_STROBE_END) && slot_end;
  assign wait_hold     = WAIT_EN && at_strobe_end && !bus.ready;
  assign freeze        = wait_hold && (wait_cnt_reg != WAIT_LIMIT);
  assign timeout_hit   = wait_hold && (wait_cnt_reg == WAIT_LIMIT);
  assign wait_cnt_next = freeze ? wait_cnt_reg + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Opcode and strap are captured once per instruction, at its boundary.
  always_ff @(posedge clk) begin
    if (reset || instr_end) begin
      instr_reg <= decode_instr(bus.IR, bus.mc_len, bus.EA);
    end
  end

  logic cyc0, cyc1, ale_win, psen_win, strobe_win, psen_act;

  always_comb begin
    cyc0       = (cycles == 2'd0);
    cyc1       = (cycles == 2'd1);
    ale_win    = (slot == T_ALE0) || (slot == T_ALE0 + 4'd1) ||
                 (slot == T_ALE1) || (slot == T_ALE1 + 4'd1);
    psen_win   = ((slot >= T_PSEN0) && (slot <= T_STROBE_END)) || (slot >= T_PSEN1);
    strobe_win = instr_reg.movx && cyc1 && (slot <= T_STROBE_END);
    psen_act   = psen_win && !instr_reg.ea_l &&
                 !(instr_reg.movx && cyc0 && (slot >= T_PSEN1)) &&
                 !(instr_reg.movx && cyc1 && (slot <= T_STROBE_END));

    bus.Phase        = 1'b0;
    bus.state        = 3'd1;
    bus.cycles       = 2'd0;
    bus.ALE          = 1'b0;
    bus.PSEN_n       = 1'b1;
    bus.RD_n         = 1'b1;
    bus.WR_n         = 1'b1;
    bus.instr_start  = 1'b0;
    bus.instr_done   = 1'b0;
    bus.wait_timeout = 1'b0;
    // Outputs drop to idle on any reset clock, even mid-strobe.
    if (!reset) begin
      bus.Phase        = slot[0];
      bus.state        = slot[3:1] + 3'd1;
      bus.cycles       = cycles;
      bus.ALE          = ale_win && !(instr_reg.movx && cyc1 && (slot < T_PSEN0));
      bus.PSEN_n       = !psen_act;
      bus.RD_n         = !(strobe_win && !instr_reg.wr);
      bus.WR_n         = !(strobe_win && instr_reg.wr);
      bus.instr_start  = cyc0 && (slot == 4'd0) && div_zero;
      bus.instr_done   = instr_end;
      bus.wait_timeout = timeout_hit;
    end
  end

endmodule

// File: tb/tb_mc_timing_gen.sv
// Directed bench for mc_timing_gen: per-clock expected vectors go into a
// scoreboard queue as stimulus is applied and are checked at the falling edge.
module tb_mc_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_timing_gen_if bus_a ();
  mc_timing_gen_if bus_b ();

  mc_timing_gen #(.CLK_DIV(1), .WAIT_EN(1'b1), .WAIT_MAX(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mc_timing_gen #(.CLK_DIV(2), .WAIT_EN(1'b1), .WAIT_MAX(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic       phase;
    logic [2:0] state;
    logic [1:0] cyc;
    logic       ale;
    logic       psen_n;
    logic       rd_n;
    logic       wr_n;
    logic       start;
    logic       done;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{phase: 1'b0, state: 3'd1, cyc: 2'd0, ale: 1'b0, psen_n: 1'b1,
          rd_n: 1'b1, wr_n: 1'b1, start: 1'b0, done: 1'b0, tmo: 1'b0};
    return e;
  endfunction

  // id 0: NOP; 1: MOVX read; 2: MOVX write, 2 wait clocks; 3: MOVX read timeout;
  // 4: MOVX read, ready rises as the limit is reached; 5: CLK_DIV=2, EA=1, 4 MCs
  function automatic exp_t make_exp(int id, int k);
    exp_t e;
    int f, tl, nmc, t, c;
    f   = (id == 2) ? 2 : ((id == 3 || id == 4) ? 3 : 0);
    if (id == 5)          tl = k / 2;
    else if (k <= 17)     tl = k;
    else if (k < 17 + f)  tl = 17;
    else                  tl = k - f;
    nmc = (id == 0) ? 1 : ((id == 5) ? 4 : 2);
    t   = tl % 12;
    c   = (tl / 12) % nmc;
    e        = reset_exp();
    e.phase  = 1'(t % 2);
    e.state  = 3'(t / 2 + 1);
    e.cyc    = 2'(c);
    case (id)
      0: begin
        e.ale    = k inside {1, 2, 7, 8};
        e.psen_n = !(k inside {[3:5], [9:11]});
        e.done   = (k == 11);
        e.start  = (k == 0) || (k == 12);
      end
      1: begin
        e.ale    = k inside {1, 2, 7, 8, 19, 20};
        e.psen_n = !(k inside {[3:5], [21:23]});
        e.rd_n   = !(k inside {[12:17]});
        e.done   = (k == 23);
        e.start  = (k == 0) || (k == 24);
      end
      2: begin
        e.ale    = k inside {1, 2, 7, 8, 21, 22};
        e.psen_n = !(k inside {[3:5], [23:25]});
        e.wr_n   = !(k inside {[12:19]});
        e.done   = (k == 25);
        e.start  = (k == 0) || (k == 26);
      end
      3, 4: begin
        e.ale    = k inside {1, 2, 7, 8, 22, 23};
        e.psen_n = !(k inside {[3:5], [24:26]});
        e.rd_n   = !(k inside {[12:20]});
        e.done   = (k == 26);
        e.start  = (k == 0) || (k == 27);
        e.tmo    = (id == 3) && (k == 20);
      end
      default: begin
        e.ale    = t inside {1, 2, 7, 8};
        e.psen_n = 1'b1;
        e.done   = (k == 95);
        e.start  = (k == 0) || (k == 96);
      end
    endcase
    return e;
  endfunction

  function automatic logic ready_for(int id, int k);
    case (id)
      2:       return !(k inside {17, 18});
      3:       return 1'b0;
      4:       return !(k inside {[17:19]});
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t observe(bit sel);
    exp_t o;
    if (sel)
      o = {bus_b.Phase, bus_b.state, bus_b.cycles, bus_b.ALE, bus_b.PSEN_n, bus_b.RD_n,
           bus_b.WR_n, bus_b.instr_start, bus_b.instr_done, bus_b.wait_timeout};
    else
      o = {bus_a.Phase, bus_a.state, bus_a.cycles, bus_a.ALE, bus_a.PSEN_n, bus_a.RD_n,
           bus_a.WR_n, bus_a.instr_start, bus_a.instr_done, bus_a.wait_timeout};
    return o;
  endfunction

  task automatic check_one(string tag, bit sel, int k);
    exp_t e, o;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s clk=%0d scoreboard empty", tag, k);
    end else begin
      e = sb.pop_front();
      o = observe(sel);
      assert (o === e) else begin
        errors++;
        $error("FAIL %s clk=%0d observed=%b required=%b (ph,st,cyc,ale,psen,rd,wr,start,done,tmo)",
               tag, k, o, e);
      end
    end
  endtask

  task automatic apply_reset(input logic [7:0] ir);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus_a.IR    = ir;
    bus_a.ready = 1'b1;
    sb.push_back(reset_exp());
    @(negedge clk);
    check_one("reset_a", 1'b0, -1);
    sb.push_back(reset_exp());
    check_one("reset_b", 1'b1, -1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_test(string tag, int id, int n, bit sel);
    for (int k = 0; k < n; k++) begin
      bus_a.ready = ready_for(id, k);
      sb.push_back(make_exp(id, k));
      @(negedge clk);
      check_one(tag, sel, k);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus_a.EA = 1'b0; bus_a.IR = 8'h00; bus_a.mc_len = 2'd0; bus_a.ready = 1'b1;
    bus_b.EA = 1'b1; bus_b.IR = 8'h00; bus_b.mc_len = 2'd3; bus_b.ready = 1'b1;

    apply_reset(8'h00);
    run_test("nop", 0, 13, 1'b0);

    apply_reset(8'hE0);
    run_test("movx_rd", 1, 25, 1'b0);

    apply_reset(8'hF2);
    run_test("movx_wr_wait", 2, 27, 1'b0);

    apply_reset(8'hE0);
    run_test("movx_timeout", 3, 28, 1'b0);

    apply_reset(8'hE0);
    run_test("ready_at_max", 4, 28, 1'b0);

    apply_reset(8'h00);
    run_test("div2_ea1_4mc", 5, 97, 1'b1);

    // Reset pulse on clock 14 of a MOVX read, then a fresh instruction.
    apply_reset(8'hE0);
    for (int k = 0; k < 22; k++) begin
      bus_a.ready = 1'b1;
      if (k == 14) reset = 1'b1;
      if (k == 15) reset = 1'b0;
      if (k < 14)       sb.push_back(make_exp(1, k));
      else if (k == 14) sb.push_back(reset_exp());
      else              sb.push_back(make_exp(1, k - 15));
      @(negedge clk);
      check_one("mid_reset", 1'b0, k);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
